// File: rtl/rgb_matrix_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_matrix_scan_driver_pkg
//  Purpose  : Shared definitions for the RGB matrix scan driver: row-scan FSM
//             state encodings, colour slot order inside the 74HC595 chain
//             and a width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rgb_matrix_scan_driver_pkg;

    // Row-scan FSM state register type and encodings
    typedef logic [1:0] scan_state_t;

    localparam logic [1:0] c_ST_CLEAR   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT   = 2'd1;
    localparam logic [1:0] c_ST_LATCH   = 2'd2;
    localparam logic [1:0] c_ST_DISPLAY = 2'd3;

    // Slot of each colour inside the serial word; slot 0 leaves the chain
    // first, so blue is shifted first and red[COLS-1] is the final bit.
    localparam int c_SLOT_BLUE  = 0;
    localparam int c_SLOT_GREEN = 1;
    localparam int c_SLOT_RED   = 2;

    // A row dwell is always this many brightness steps long
    localparam int c_DWELL_STEPS = 16;

    // Ceiling log2, never smaller than 1 so every counter has at least one bit
    function automatic int f_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : rgb_matrix_scan_driver_pkg
`default_nettype wire

// File: rtl/rgb_matrix_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_matrix_scan_driver_if
//  Purpose  : Frame-source side of the scan driver. The render logic (master)
//             presents three colour planes, a load strobe and the brightness
//             level; the driver (slave) returns the end-of-frame pulse.
//  Signals  : red_frame/green_frame/blue_frame [ROWS*COLS] planes,
//             row r at [r*COLS +: COLS]; frame_load 1-cycle strobe;
//             brightness 0..15; frame_done 1-cycle pulse per frame.
//  Revision : 1.0 - initial release
// ============================================================================
interface rgb_matrix_scan_driver_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] red_frame;
    logic [ROWS*COLS-1:0] green_frame;
    logic [ROWS*COLS-1:0] blue_frame;
    logic                 frame_load;
    logic [3:0]           brightness;
    logic                 frame_done;

    modport master (
        output red_frame, green_frame, blue_frame, frame_load, brightness,
        input  frame_done
    );

    modport slave (
        input  red_frame, green_frame, blue_frame, frame_load, brightness,
        output frame_done
    );
endinterface : rgb_matrix_scan_driver_if
`default_nettype wire

// File: rtl/rgb_matrix_scan_driver_hc595_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_matrix_scan_driver_hc595_serializer
//  Purpose  : Shifts NBITS into a 74HC595 chain, LSB first, then pulses the
//             storage clock. Each bit lasts 2*CLK_DIV cycles (SH_CP low for
//             the first half, high for the second); the latch pulse lasts
//             CLK_DIV cycles. A start restarts the sequence.
//  Ports    : clk, rst_n (async, active low)
//             i_start  - begin a new word (data captured the same cycle)
//             i_data   - word to shift, bit 0 first
//             o_ds, o_sh_cp, o_st_cp - registered chain pins
//             o_shift_end - last cycle of the shift phase
//             o_done      - last cycle of the latch phase
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_matrix_scan_driver_hc595_serializer
    import rgb_matrix_scan_driver_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int NBITS   = 24
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    input  wire logic [NBITS-1:0] i_data,
    output logic                  o_ds,
    output logic                  o_sh_cp,
    output logic                  o_st_cp,
    output logic                  o_shift_end,
    output logic                  o_done
);
    localparam int c_BIT_W = f_clog2(NBITS);
    localparam int c_DIV_W = f_clog2(2 * CLK_DIV);

    localparam logic [c_BIT_W-1:0] c_BIT_LAST    = c_BIT_W'(NBITS - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_SH_LAST = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LT_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF    = c_DIV_W'(CLK_DIV);

    logic               r_shift;
    logic               r_latch;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_DIV_W-1:0] r_div;
    logic [NBITS-1:0]   r_data;

    logic               w_shift_n;
    logic               w_latch_n;
    logic [c_BIT_W-1:0] w_bit_n;
    logic [c_DIV_W-1:0] w_div_n;
    logic [NBITS-1:0]   w_data_n;

    // Next-state of the sequencer. The pins are registered from these next
    // values so they line up exactly with the counter that produced them.
    always_comb begin
        w_shift_n   = r_shift;
        w_latch_n   = r_latch;
        w_bit_n     = r_bit;
        w_div_n     = r_div;
        w_data_n    = r_data;
        o_shift_end = 1'b0;
        o_done      = 1'b0;
        if (i_start) begin
            w_shift_n = 1'b1;
            w_latch_n = 1'b0;
            w_bit_n   = '0;
            w_div_n   = '0;
            w_data_n  = i_data;
        end else if (r_shift) begin
            if (r_div == c_DIV_SH_LAST) begin
                w_div_n = '0;
                if (r_bit == c_BIT_LAST) begin
                    w_shift_n   = 1'b0;
                    w_latch_n   = 1'b1;
                    o_shift_end = 1'b1;
                end else begin
                    w_bit_n = r_bit + 1'b1;
                end
            end else begin
                w_div_n = r_div + 1'b1;
            end
        end else if (r_latch) begin
            if (r_div == c_DIV_LT_LAST) begin
                w_latch_n = 1'b0;
                w_div_n   = '0;
                o_done    = 1'b1;
            end else begin
                w_div_n = r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 1'b0;
            r_latch <= 1'b0;
            r_bit   <= '0;
            r_div   <= '0;
            r_data  <= '0;
            o_ds    <= 1'b0;
            o_sh_cp <= 1'b0;
            o_st_cp <= 1'b0;
        end else begin
            r_shift <= w_shift_n;
            r_latch <= w_latch_n;
            r_bit   <= w_bit_n;
            r_div   <= w_div_n;
            r_data  <= w_data_n;
            o_ds    <= w_shift_n & w_data_n[w_bit_n];
            o_sh_cp <= w_shift_n & (w_div_n >= c_DIV_HALF);
            o_st_cp <= w_latch_n;
        end
    end

endmodule : rgb_matrix_scan_driver_hc595_serializer
`default_nettype wire

// File: rtl/rgb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_matrix_scan_driver
//  Purpose  : Row-scanning driver for an RGB LED matrix behind a 74HC595
//             column chain. Per row: shift blue/green/red column bits, latch,
//             then enable the row cathode for 16*DWELL_UNIT cycles with OE
//             PWM'd by brightness. Frames are double buffered and swapped
//             only at the start of row 0.
//  Ports    : CLOCK, RESET_N (async, active low)
//             fb      - frame source interface (slave side)
//             DS, SH_CP, ST_CP, SRCLR_N, oe - chain pins (oe active low)
//             CAT[ROWS] - one-hot cathode, row r drives CAT[ROWS-1-r]
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_matrix_scan_driver
    import rgb_matrix_scan_driver_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CLK_DIV    = 16,
    parameter int DWELL_UNIT = 64
) (
    input  wire logic               CLOCK,
    input  wire logic               RESET_N,
    rgb_matrix_scan_driver_if.slave fb,
    output logic                    DS,
    output logic                    SH_CP,
    output logic                    ST_CP,
    output logic                    SRCLR_N,
    output logic                    oe,
    output logic [ROWS-1:0]         CAT
);
    localparam int c_NBITS = 3 * COLS;
    localparam int c_PLANE = ROWS * COLS;
    localparam int c_DWELL = c_DWELL_STEPS * DWELL_UNIT;
    localparam int c_CLEAR = 2 * CLK_DIV;
    localparam int c_CNT_W = f_clog2((c_DWELL > c_CLEAR) ? c_DWELL : c_CLEAR);
    localparam int c_ON_W  = c_CNT_W + 1;
    localparam int c_ROW_W = f_clog2(ROWS);

    localparam logic [c_CNT_W-1:0] c_CLEAR_LAST = c_CNT_W'(c_CLEAR - 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(c_DWELL - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST   = c_ROW_W'(ROWS - 1);

    scan_state_t        r_state;
    logic [c_ROW_W-1:0] r_row;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bright;
    logic               r_frame_done;

    logic [c_PLANE-1:0] r_act_red, r_act_green, r_act_blue;
    logic [c_PLANE-1:0] r_pend_red, r_pend_green, r_pend_blue;
    logic               r_pend_valid;

    logic               w_clear_end;
    logic               w_dwell_end;
    logic               w_enter_shift;
    logic [c_ROW_W-1:0] w_row_nxt;
    logic               w_swap;
    logic [c_PLANE-1:0] w_src_red, w_src_green, w_src_blue;
    logic [COLS-1:0]    w_row_red, w_row_green, w_row_blue;
    logic [c_NBITS-1:0] w_ser_data;
    logic [ROWS-1:0]    w_cat_onehot;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_ON_W-1:0]  w_on_cycles;
    logic               w_ser_shift_end;
    logic               w_ser_done;

    assign w_clear_end   = (r_state == c_ST_CLEAR) && (r_cnt == c_CLEAR_LAST);
    assign w_dwell_end   = (r_state == c_ST_DISPLAY) && (r_cnt == c_DWELL_LAST);
    assign w_enter_shift = w_clear_end | w_dwell_end;
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_on_cycles   = c_ON_W'((int'(r_bright) + 1) * DWELL_UNIT);

    // Row that the upcoming SHIFT phase serves; CLEAR always leads to row 0
    always_comb begin
        w_row_nxt = r_row;
        if (w_clear_end) begin
            w_row_nxt = '0;
        end else if (w_dwell_end) begin
            w_row_nxt = (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        end
    end

    // Swap only on the way into row 0 so a frame is never torn
    assign w_swap      = w_enter_shift && (w_row_nxt == '0) && r_pend_valid;
    // The serializer captures its word on the swap edge, so it must see the
    // buffer that becomes active on that same edge.
    assign w_src_red   = w_swap ? r_pend_red   : r_act_red;
    assign w_src_green = w_swap ? r_pend_green : r_act_green;
    assign w_src_blue  = w_swap ? r_pend_blue  : r_act_blue;

    always_comb begin
        w_row_red   = '0;
        w_row_green = '0;
        w_row_blue  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_row_nxt == c_ROW_W'(r)) begin
                w_row_red   = w_src_red[r*COLS +: COLS];
                w_row_green = w_src_green[r*COLS +: COLS];
                w_row_blue  = w_src_blue[r*COLS +: COLS];
            end
        end
        w_ser_data = '0;
        w_ser_data[c_SLOT_BLUE*COLS  +: COLS] = w_row_blue;
        w_ser_data[c_SLOT_GREEN*COLS +: COLS] = w_row_green;
        w_ser_data[c_SLOT_RED*COLS   +: COLS] = w_row_red;
    end

    always_comb begin
        w_cat_onehot = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_cat_onehot[ROWS-1-r] = (r_row == c_ROW_W'(r));
        end
    end

    rgb_matrix_scan_driver_hc595_serializer #(
        .CLK_DIV (CLK_DIV),
        .NBITS   (c_NBITS)
    ) u_serializer (
        .clk         (CLOCK),
        .rst_n       (RESET_N),
        .i_start     (w_enter_shift),
        .i_data      (w_ser_data),
        .o_ds        (DS),
        .o_sh_cp     (SH_CP),
        .o_st_cp     (ST_CP),
        .o_shift_end (w_ser_shift_end),
        .o_done      (w_ser_done)
    );

    // Row FSM, dwell counter, PWM and cathode drive
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= c_ST_CLEAR;
            r_row        <= '0;
            r_cnt        <= '0;
            r_bright     <= '0;
            r_frame_done <= 1'b0;
            SRCLR_N      <= 1'b0;
            oe           <= 1'b1;
            CAT          <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_CLEAR: begin
                    if (w_clear_end) begin
                        r_state <= c_ST_SHIFT;
                        r_cnt   <= '0;
                        SRCLR_N <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_ser_shift_end) begin
                        r_state <= c_ST_LATCH;
                    end
                end
                c_ST_LATCH: begin
                    // Brightness is frozen for the whole dwell of this row;
                    // the first dwell cycle is always lit (b+1 >= 1 step).
                    if (w_ser_done) begin
                        r_state  <= c_ST_DISPLAY;
                        r_cnt    <= '0;
                        r_bright <= fb.brightness;
                        CAT      <= w_cat_onehot;
                        oe       <= 1'b0;
                    end
                end
                c_ST_DISPLAY: begin
                    if (w_dwell_end) begin
                        r_state      <= c_ST_SHIFT;
                        r_cnt        <= '0;
                        r_row        <= w_row_nxt;
                        r_frame_done <= (r_row == c_ROW_LAST);
                        CAT          <= '0;
                        oe           <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        oe    <= ({1'b0, w_cnt_inc} >= w_on_cycles);
                    end
                end
                default: begin
                    r_state <= c_ST_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Double buffer. A load coinciding with the swap lands in pending after
    // the old pending moved to active, so pending stays valid.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_act_red    <= '0;
            r_act_green  <= '0;
            r_act_blue   <= '0;
            r_pend_red   <= '0;
            r_pend_green <= '0;
            r_pend_blue  <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_swap) begin
                r_act_red    <= r_pend_red;
                r_act_green  <= r_pend_green;
                r_act_blue   <= r_pend_blue;
                r_pend_valid <= 1'b0;
            end
            if (fb.frame_load) begin
                r_pend_red   <= fb.red_frame;
                r_pend_green <= fb.green_frame;
                r_pend_blue  <= fb.blue_frame;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign fb.frame_done = r_frame_done;

endmodule : rgb_matrix_scan_driver
`default_nettype wire

// File: tb/tb_rgb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_matrix_scan_driver
//  Purpose  : Self-checking bench for rgb_matrix_scan_driver. A frame-level
//             model (active/pending planes per row) predicts the serial
//             word, cathode, OE on-time and frame pulse of every row slot.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_matrix_scan_driver;
    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int CLK_DIV    = 2;
    localparam int DWELL_UNIT = 4;
    localparam int NBITS      = 3 * COLS;
    localparam int DWELL      = 16 * DWELL_UNIT;
    localparam int SLOT       = 2 * CLK_DIV * NBITS + CLK_DIV + DWELL;

    logic            CLOCK = 1'b0;
    logic            RESET_N;
    logic            DS, SH_CP, ST_CP, SRCLR_N, oe;
    logic [ROWS-1:0] CAT;

    rgb_matrix_scan_driver_if #(.ROWS(ROWS), .COLS(COLS)) fb ();

    rgb_matrix_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DWELL_UNIT(DWELL_UNIT)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .fb(fb),
        .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP), .SRCLR_N(SRCLR_N),
        .oe(oe), .CAT(CAT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: planes held per row
    logic [COLS-1:0] m_act_r[ROWS], m_act_g[ROWS], m_act_b[ROWS];
    logic [COLS-1:0] m_pend_r[ROWS], m_pend_g[ROWS], m_pend_b[ROWS];
    logic [COLS-1:0] ld_r[ROWS], ld_g[ROWS], ld_b[ROWS];
    bit              m_pend_valid;
    bit              m_defer;
    bit              directed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_act_r[r] = '0; m_act_g[r] = '0; m_act_b[r] = '0;
            m_pend_r[r] = '0; m_pend_g[r] = '0; m_pend_b[r] = '0;
        end
        m_pend_valid = 0;
        m_defer      = 0;
    endtask

    task automatic model_load();
        m_pend_r = ld_r; m_pend_g = ld_g; m_pend_b = ld_b;
        m_pend_valid = 1;
    endtask

    // New plane data onto the interface; the caller strobes frame_load
    task automatic gen_load_data();
        for (int r = 0; r < ROWS; r++) begin
            ld_r[r] = COLS'($urandom);
            ld_g[r] = directed ? '0 : COLS'($urandom);
            ld_b[r] = COLS'($urandom);
            if (directed && r == 0) begin
                ld_r[r] = 8'hA5;
                ld_b[r] = 8'h01;
            end
            fb.red_frame[r*COLS +: COLS]   = ld_r[r];
            fb.green_frame[r*COLS +: COLS] = ld_g[r];
            fb.blue_frame[r*COLS +: COLS]  = ld_b[r];
        end
        directed = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ds"},    64'(DS),      64'd0);
        check({tag, "_shcp"},  64'(SH_CP),   64'd0);
        check({tag, "_stcp"},  64'(ST_CP),   64'd0);
        check({tag, "_srclr"}, 64'(SRCLR_N), 64'd0);
        check({tag, "_oe"},    64'(oe),      64'd1);
        check({tag, "_cat"},   64'(CAT),     64'd0);
        check({tag, "_fd"},    64'(fb.frame_done), 64'd0);
    endtask

    // After release SRCLR_N must stay low for 2*CLK_DIV clocks; returns at
    // the negedge of the first SHIFT cycle.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge CLOCK);
            n++;
            if (SRCLR_N) break;
        end
        check({tag, "_clear_len"}, 64'(n), 64'(2 * CLK_DIV));
        check({tag, "_shift0_shcp"}, 64'(SH_CP), 64'd0);
    endtask

    // Observes one full row slot starting at the negedge of its first cycle
    task automatic observe_row(input int row, input int exp_fd, input int load_at, input int chg_at);
        logic [NBITS-1:0] obs_bits, exp_bits;
        logic [ROWS-1:0]  cat_seen;
        logic [3:0]       b;
        logic             prev_sh, fd0;
        int rises, nst, noe, ncat, ghost, nfd;
        string t;
        obs_bits = '0; cat_seen = '0;
        rises = 0; nst = 0; noe = 0; ncat = 0; ghost = 0; nfd = 0;
        b = (row == 0) ? 4'd0 : (row == 1) ? 4'd15 : (row == 2) ? 4'd7 : 4'($urandom_range(15, 0));
        fb.brightness = b;
        prev_sh = SH_CP;
        fd0 = fb.frame_done;
        for (int i = 0; i < SLOT; i++) begin
            if (SH_CP && !prev_sh) begin
                if (rises < NBITS) obs_bits[rises] = DS;
                rises++;
            end
            prev_sh = SH_CP;
            if (ST_CP) nst++;
            if (!oe) noe++;
            if (CAT != '0) begin
                ncat++;
                cat_seen = CAT;
                if (SH_CP || ST_CP) ghost++;
            end
            if (!oe && CAT == '0) ghost++;
            if (fb.frame_done) nfd++;
            fb.frame_load = (i == load_at);
            if (i == load_at) begin
                gen_load_data();
                if (row == ROWS - 1 && i == SLOT - 1) m_defer = 1;
                else model_load();
            end
            if (i == chg_at) fb.brightness = ~b;
            @(negedge CLOCK);
        end
        fb.frame_load = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            exp_bits[c]          = m_act_b[row][c];
            exp_bits[COLS + c]   = m_act_g[row][c];
            exp_bits[2*COLS + c] = m_act_r[row][c];
        end
        t = $sformatf("row%0d", row);
        check({t, "_bits"},   64'(obs_bits), 64'(exp_bits));
        check({t, "_rises"},  64'(rises),    64'(NBITS));
        check({t, "_stcp"},   64'(nst),      64'(CLK_DIV));
        check({t, "_oe_on"},  64'(noe),      64'((int'(b) + 1) * DWELL_UNIT));
        check({t, "_cat"},    64'(cat_seen), 64'(1 << (ROWS - 1 - row)));
        check({t, "_cat_len"}, 64'(ncat),    64'(DWELL));
        check({t, "_ghost"},  64'(ghost),    64'd0);
        check({t, "_fd_first"}, 64'(fd0),    64'(exp_fd));
        check({t, "_fd_count"}, 64'(nfd),    64'(exp_fd));
    endtask

    // One whole frame; load_row/load_at pairs select optional load strobes
    task automatic run_frame(input int exp_fd, input int l1_row, input int l1_at,
                             input int l2_row, input int l2_at, input int chg_row);
        if (m_pend_valid) begin
            m_act_r = m_pend_r; m_act_g = m_pend_g; m_act_b = m_pend_b;
            m_pend_valid = 0;
        end
        if (m_defer) begin
            model_load();
            m_defer = 0;
        end
        for (int r = 0; r < ROWS; r++) begin
            observe_row(r, (r == 0) ? exp_fd : 0,
                        (r == l1_row) ? l1_at : ((r == l2_row) ? l2_at : -1),
                        (r == chg_row) ? 120 : -1);
        end
    endtask

    initial begin
        RESET_N        = 1'b0;
        fb.red_frame   = '0;
        fb.green_frame = '0;
        fb.blue_frame  = '0;
        fb.frame_load  = 1'b0;
        fb.brightness  = 4'd0;
        directed       = 0;
        model_reset();

        // Reset values while held, then CLEAR timing after release
        repeat (3) @(negedge CLOCK);
        check_reset_outputs("reset_hold");
        RESET_N = 1'b1;
        wait_clear("rel1");

        // Frame 1: empty buffers; directed load in row 3, brightness change mid-dwell
        directed = 1;
        run_frame(0, 3, 10, -1, -1, 4);
        // Frame 2: shows directed data; load in row 2 and on the swap cycle
        run_frame(1, 2, 10, 7, SLOT - 1, -1);
        // Frame 3: row-2 load data; swap-cycle load still pending
        run_frame(1, -1, -1, -1, -1, -1);
        // Frame 4: swap-cycle data; two loads, last one must win
        run_frame(1, 1, 5, 4, 50, 6);
        // Frame 5: second of the two loads
        run_frame(1, -1, -1, -1, -1, -1);

        // Reset during the SHIFT phase of row 5
        repeat (5 * SLOT + 30) @(negedge CLOCK);
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        model_reset();
        repeat (2) @(negedge CLOCK);
        check_reset_outputs("reset_mid_hold");
        RESET_N = 1'b1;
        wait_clear("rel2");
        run_frame(0, -1, -1, -1, -1, -1);
        run_frame(1, -1, -1, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rgb_matrix_scan_driver
`default_nettype wire
